// File: rtl/ysyx_22050518_wb_pkg.sv
// Shared constants for the write-back scheduler: requester count, requester
// indices and the pending-counter geometry.
package ysyx_22050518_wb_pkg;
    localparam int NREQ    = 3;
    localparam int CNT_W   = 2;
    localparam int REQ_EXU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;
    localparam int CNT_MAX = 3;
endpackage

// File: rtl/ysyx_22050518_rr_arb.sv
// Generic N-way round-robin arbiter: one-hot grant to the first valid requester
// starting at the pointer; the pointer moves just past each winner.
module ysyx_22050518_rr_arb #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] valid_i,
    output logic [N-1:0] grant_o,
    output logic         gnt_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx;

    // The (j+k)%N index is constant per unrolled iteration, so no variable bit-select
    always_comb begin
        grant_o = '0;
        gnt_o   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (ptr_q == IW'(j) && !gnt_o && valid_i[(j + k) % N]) begin
                    grant_o[(j + k) % N] = 1'b1;
                    idx                  = IW'((j + k) % N);
                    gnt_o                = 1'b1;
                end
            end
        end
        ptr_d = ptr_q;
        if (gnt_o) ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ysyx_22050518_wb_sched.sv
// Write-back scheduler: round-robin share of the register-file write port plus
// per-register pending counters that drive the decode RAW/WAW stall.
module ysyx_22050518_wb_sched
    import ysyx_22050518_wb_pkg::CNT_MAX;
#(
    parameter int NREQ  = ysyx_22050518_wb_pkg::NREQ,
    parameter int CNT_W = ysyx_22050518_wb_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [5*NREQ-1:0]  req_rdr,
    input  logic [64*NREQ-1:0] req_data,
    output logic               wb_en_o,
    output logic [4:0]         wb_rdr_o,
    output logic [63:0]        wb_data_o,
    input  logic               iss_en,
    input  logic [4:0]         iss_rd,
    input  logic [4:0]         chk_rs1,
    input  logic [4:0]         chk_rs2,
    input  logic               chk_use1,
    input  logic               chk_use2,
    input  logic [4:0]         chk_rd,
    input  logic               chk_rd_en,
    output logic               hazard_o,
    output logic [31:0]        busy_o,
    output logic               err_o
);
    logic [NREQ-1:0]        gnt;
    logic                   gnt_vld;
    logic [4:0]             win_rdr;
    logic [63:0]            win_data;
    logic                   wb_en_q;
    logic [4:0]             wb_rdr_q;
    logic [63:0]            wb_data_q;
    logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   inc, dec;

    ysyx_22050518_rr_arb #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (req_valid),
        .grant_o (gnt),
        .gnt_o   (gnt_vld)
    );

    assign req_ready = gnt;

    always_comb begin
        win_rdr  = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_rdr  = req_rdr[5*i +: 5];
                win_data = req_data[64*i +: 64];
            end
        end
    end

    // Writes to x0 still consume a grant but never reach the register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_rdr_q  <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q <= gnt_vld && (win_rdr != 5'd0);
            if (gnt_vld) begin
                wb_rdr_q  <= win_rdr;
                wb_data_q <= win_data;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        inc   = 1'b0;
        dec   = 1'b0;
        for (int r = 1; r < 32; r++) begin
            inc = iss_en && (iss_rd == 5'(r));
            dec = wb_en_q && (wb_rdr_q == 5'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CNT_W'(CNT_MAX)) err_d = 1'b1;
                else                             cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // No bypass: a source clears only after its write has landed
    assign hazard_o = (chk_use1 && cnt_q[chk_rs1] != '0)
                   || (chk_use2 && cnt_q[chk_rs2] != '0)
                   || (chk_rd_en && chk_rd != 5'd0 && cnt_q[chk_rd] == CNT_W'(CNT_MAX));

    for (genvar r = 0; r < 32; r++) begin : g_busy
        assign busy_o[r] = |cnt_q[r];
    end

    assign wb_en_o   = wb_en_q;
    assign wb_rdr_o  = wb_rdr_q;
    assign wb_data_o = wb_data_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_ysyx_22050518_wb_sched.sv
// Scoreboard bench: stimulus queues expected grants and write-backs; a negedge
// monitor pops and compares them as the DUT presents handshakes and wb outputs.
module tb_ysyx_22050518_wb_sched;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req_valid, req_ready;
    logic [14:0]  req_rdr;
    logic [191:0] req_data;
    logic         wb_en_o;
    logic [4:0]   wb_rdr_o;
    logic [63:0]  wb_data_o;
    logic         iss_en;
    logic [4:0]   iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic         chk_use1, chk_use2, chk_rd_en;
    logic         hazard_o;
    logic [31:0]  busy_o;
    logic         err_o;

    always #5 clk = ~clk;

    ysyx_22050518_wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rdr(req_rdr), .req_data(req_data),
        .wb_en_o(wb_en_o), .wb_rdr_o(wb_rdr_o), .wb_data_o(wb_data_o),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_use1(chk_use1), .chk_use2(chk_use2),
        .chk_rd(chk_rd), .chk_rd_en(chk_rd_en),
        .hazard_o(hazard_o), .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct packed {
        logic        en;
        logic [4:0]  rdr;
        logic [63:0] data;
    } wb_t;

    wb_t        exp_wb_q[$];
    logic [2:0] exp_gnt_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic       wb_due   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rdr, input logic [63:0] data);
        req_valid[i]         = 1'b1;
        req_rdr[5*i +: 5]    = rdr;
        req_data[64*i +: 64] = data;
    endtask

    task automatic expect_wb(input logic [2:0] g, input logic en, input logic [4:0] rdr,
                             input logic [63:0] data);
        wb_t e;
        e.en = en; e.rdr = rdr; e.data = data;
        exp_gnt_q.push_back(g);
        exp_wb_q.push_back(e);
    endtask

    // Monitor: grant seen this cycle -> write-back must appear next cycle
    always @(negedge clk) begin : mon
        wb_t        e;
        logic [2:0] g;
        if (wb_due) begin
            if (exp_wb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wb_unexpected actual=%0h expected=none", wb_rdr_o);
            end else begin
                e = exp_wb_q.pop_front();
                check("wb_en",   64'(wb_en_o),  64'(e.en));
                check("wb_rdr",  64'(wb_rdr_o), 64'(e.rdr));
                check("wb_data", wb_data_o,     e.data);
            end
        end else if (wb_en_o === 1'b1) begin
            checks++; failures++;
            $display("FAIL wb_spurious actual=1 expected=0 rdr=%0d", wb_rdr_o);
        end
        wb_due = 1'b0;
        if (rst_n && |(req_valid & req_ready)) begin
            if (exp_gnt_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL grant_unexpected actual=%b expected=none", req_ready);
            end else begin
                g = exp_gnt_q.pop_front();
                check("grant", 64'(req_ready), 64'(g));
            end
            wb_due = 1'b1;
        end
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_rdr = '0; req_data = '0;
        iss_en = 1'b0; iss_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0; chk_use1 = 1'b0; chk_use2 = 1'b0; chk_rd_en = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk_rs1 = 5; chk_use1 = 1'b1; chk_rs2 = 31; chk_use2 = 1'b1; chk_rd = 7; chk_rd_en = 1'b1;
        #1;
        check("rst_hazard",  64'(hazard_o),  0);
        check("rst_wb_en",   64'(wb_en_o),   0);
        check("rst_wb_rdr",  64'(wb_rdr_o),  0);
        check("rst_wb_data", wb_data_o,      0);
        check("rst_err",     64'(err_o),     0);
        check("rst_busy",    64'(busy_o),    0);
        check("rst_ready",   64'(req_ready), 0);

        // RAW on x5 cleared by an LSU write-back
        chk_use1 = 1'b0; chk_use2 = 1'b0; chk_rd_en = 1'b0;
        step(); iss_en = 1'b1; iss_rd = 5;
        step(); iss_en = 1'b0; chk_rs1 = 5; chk_use1 = 1'b1; #1;
        check("hz_raw_x5", 64'(hazard_o), 1);
        check("busy_x5",   64'(busy_o),   64'h20);
        set_req(1, 5, 64'hDEAD); expect_wb(3'b010, 1'b1, 5, 64'hDEAD);
        step(); req_valid = '0; #1;
        check("hz_during_wb", 64'(hazard_o), 1);
        step();
        check("hz_after_wb", 64'(hazard_o), 0);
        check("busy_clear",  64'(busy_o),   0);

        // CSR write to x0 leaves ptr at 0
        chk_use1 = 1'b0;
        set_req(2, 0, 64'h77); expect_wb(3'b100, 1'b0, 0, 64'h77);
        step(); req_valid = '0;
        step();
        check("x0_no_err", 64'(err_o), 0);

        // Round-robin with all three requesters
        iss_en = 1'b1; iss_rd = 10; step();
        iss_rd = 11; step();
        iss_rd = 12; step();
        iss_rd = 13; step();
        iss_en = 1'b0;
        set_req(0, 10, 64'hA); set_req(1, 11, 64'hB); set_req(2, 12, 64'hC);
        expect_wb(3'b001, 1'b1, 10, 64'hA);
        step(); set_req(0, 13, 64'hD); expect_wb(3'b010, 1'b1, 11, 64'hB);
        step(); req_valid[1] = 1'b0;   expect_wb(3'b100, 1'b1, 12, 64'hC);
        step(); req_valid[2] = 1'b0;   expect_wb(3'b001, 1'b1, 13, 64'hD);
        step(); req_valid = '0;
        step(); step();
        check("rr_busy_clear", 64'(busy_o), 0);
        check("rr_no_err",     64'(err_o),  0);

        // WAW saturation on x7 and overflow error
        iss_en = 1'b1; iss_rd = 7;
        step(); step(); step();
        iss_en = 1'b0; chk_rd = 7; chk_rd_en = 1'b1; #1;
        check("hz_waw_sat", 64'(hazard_o), 1);
        chk_rd_en = 1'b0; #1;
        check("hz_rd_en_off", 64'(hazard_o), 0);
        chk_rd_en = 1'b1;
        set_req(0, 7, 64'h71); expect_wb(3'b001, 1'b1, 7, 64'h71);
        step(); req_valid = '0;
        step();
        check("hz_waw_drop", 64'(hazard_o), 0);
        iss_en = 1'b1; step(); step(); iss_en = 1'b0; #1;
        check("err_overflow", 64'(err_o),    1);
        check("hz_sat_kept",  64'(hazard_o), 1);
        chk_rd_en = 1'b0;
        set_req(1, 7, 64'h72); expect_wb(3'b010, 1'b1, 7, 64'h72);
        step(); set_req(1, 7, 64'h73); expect_wb(3'b010, 1'b1, 7, 64'h73);
        step(); set_req(1, 7, 64'h74); expect_wb(3'b010, 1'b1, 7, 64'h74);
        step(); req_valid = '0;
        check("busy_x7_pending", 64'(busy_o[7]), 1);
        step();
        check("busy_x7_clear", 64'(busy_o[7]), 0);
        check("err_sticky",    64'(err_o),     1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("err_reset", 64'(err_o), 0);

        // Simultaneous issue and write-back of x9
        iss_en = 1'b1; iss_rd = 9; step(); iss_en = 1'b0;
        set_req(0, 9, 64'h99); expect_wb(3'b001, 1'b1, 9, 64'h99);
        step(); req_valid = '0; iss_en = 1'b1; iss_rd = 9;
        step(); iss_en = 1'b0; chk_rs1 = 9; chk_use1 = 1'b1; #1;
        check("busy_x9_same", 64'(busy_o[9]), 1);
        check("hz_x9_same",   64'(hazard_o),  1);
        check("err_x9_same",  64'(err_o),     0);
        chk_use1 = 1'b0;
        set_req(1, 9, 64'h9A); expect_wb(3'b010, 1'b1, 9, 64'h9A);
        step(); req_valid = '0;
        step();
        check("busy_x9_clear", 64'(busy_o), 0);

        // x0 write-back, then reset with requests pending
        set_req(2, 0, 64'h55); expect_wb(3'b100, 1'b0, 0, 64'h55);
        step(); req_valid = '0;
        step();
        check("x0_err",  64'(err_o),  0);
        check("x0_busy", 64'(busy_o), 0);
        iss_en = 1'b1; iss_rd = 3; step(); iss_en = 1'b0;
        set_req(0, 0, 64'h66); expect_wb(3'b001, 1'b0, 0, 64'h66);
        step(); req_valid = '0;
        set_req(0, 3, 64'h31); set_req(1, 4, 64'h41); set_req(2, 6, 64'h61);
        rst_n = 1'b0; #1;
        check("busy_pre_rst", 64'(busy_o), 64'h8);
        step(); rst_n = 1'b1; req_valid = '0; #1;
        check("mrst_wb_en",   64'(wb_en_o),  0);
        check("mrst_wb_rdr",  64'(wb_rdr_o), 0);
        check("mrst_wb_data", wb_data_o,     0);
        check("mrst_busy",    64'(busy_o),   0);
        check("mrst_err",     64'(err_o),    0);
        set_req(0, 0, 64'h11); set_req(1, 0, 64'h22);
        expect_wb(3'b001, 1'b0, 0, 64'h11);
        step(); req_valid = '0;
        step(); step();
        check("queues_drained", 64'(exp_wb_q.size() + exp_gnt_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22050518_wb_sched.md
# ysyx_22050518_wb_sched

Write-back scheduler and register scoreboard for the ysyx_22050518 core. Shares the single register-file write port among the EXU, LSU and CSR result producers with round-robin arbitration, replacing the fixed exu > lsu > csr priority mux. Tracks in-flight destination registers with per-register pending counters and tells the decode stage when an instruction must stall for a RAW or WAW hazard. Sits between the execute-side units and the register group inside the first stage.

## Interface
Parameters:
- NREQ, 3: number of write-back requesters. Index 0 is EXU, 1 is LSU, 2 is CSR.
- CNT_W, 2: width of each per-register pending counter. The counter saturates at 3.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  requester i has a result to write back
- req_ready  out  NREQ  one-hot grant for this cycle; the handshake completes when valid&ready
- req_rdr  in  5*NREQ  destination register of requester i, at bits [5i+4:5i]
- req_data  in  64*NREQ  result of requester i, at bits [64i+63:64i]
- wb_en_o  out  1  register-file write enable
- wb_rdr_o  out  5  register-file write address
- wb_data_o  out  64  register-file write data
- iss_en  in  1  decode is issuing an instruction that writes iss_rd this cycle
- iss_rd  in  5  destination register of the issuing instruction
- chk_rs1, chk_rs2  in  5 each  source registers of the instruction in decode
- chk_use1, chk_use2  in  1 each  the instruction actually reads rs1 / rs2
- chk_rd, chk_rd_en  in  5, 1  destination of the instruction in decode, and whether it writes one
- hazard_o  out  1  combinational; decode must hold this cycle
- busy_o  out  32  bit r = (cnt[r] != 0); debug and trace only
- err_o  out  1  sticky protocol-violation flag

## Operation
- Arbitration: a round-robin pointer ptr in 0..2 gives priority order ptr, ptr+1, ptr+2 (mod 3).
  - req_ready is one-hot to the first valid requester in that order, and zero when no requester is valid.
  - On a grant to i, ptr becomes (i+1) mod 3.
- Output register: on a grant, the next edge loads wb_rdr_o and wb_data_o from the winner. wb_en_o is set to 1 only if the winner's rdr is not 0, otherwise 0. With no grant, wb_en_o is 0 and the address and data hold their values.
- Scoreboard: one counter cnt[r] per register, r = 1..31; cnt[0] is always 0.
  - Increment: iss_en with iss_rd != 0.
  - Decrement: on an edge where wb_en_o = 1, for register wb_rdr_o.
  - If both hit the same register on the same edge, the counter is unchanged.
- hazard_o = (chk_use1 && cnt[chk_rs1] != 0) || (chk_use2 && cnt[chk_rs2] != 0) || (chk_rd_en && chk_rd != 0 && cnt[chk_rd] == 3).
- Issue contract: the issuer asserts iss_en only when hazard_o = 0.
- err_o is set, and stays set until reset, on either violation below. In both cases the counter keeps its value.
  - Increment of a counter already at 3.
  - Decrement of a counter at 0.

## Timing
- Reset values: wb_en_o=0, wb_rdr_o=0, wb_data_o=0, ptr=0, every cnt=0, err_o=0, busy_o=0.
- req_ready and hazard_o are combinational, with no registered inputs in their path.
- Handshake: a requester holds req_valid, req_rdr and req_data stable until it sees req_ready=1.
  - At most one grant per cycle.
  - A granted result appears on wb_*_o one cycle later and stays valid for exactly one cycle.
- Hazard clearing: cnt clears on the edge where the register file writes. hazard_o deasserts in the cycle after wb_en_o is high, so the register-file read in that cycle sees the new value. No bypass is used.
- Back-to-back grants are allowed. With all three requesters valid continuously, the grant order is 0,1,2,0,1,2...
- Reset asserted mid-operation: all state returns to the reset values on that edge, and pending results are dropped.

## Structure
- Shared package ysyx_22050518_wb_pkg holds:
  - NREQ and CNT_W;
  - requester index constants REQ_EXU=0, REQ_LSU=1, REQ_CSR=2;
  - the counter maximum CNT_MAX=3.
- Sub-module ysyx_22050518_rr_arb: a generic NREQ-way round-robin arbiter containing the pointer register and the one-hot grant logic.
- The scoreboard counters and the output register stay in the top module.

## Test plan
- Reset, then idle: all outputs at their reset values, and hazard_o=0 for any check values.
- Issue x5 (iss_en, iss_rd=5), then check with chk_rs1=5, chk_use1=1: hazard_o=1. LSU returns rdr=5, data=0xDEAD: it is granted at once; wb_en_o=1, wb_rdr_o=5, wb_data_o=0xDEAD the next cycle; hazard_o=0 the cycle after that.
- EXU, LSU and CSR all valid for 3 cycles starting from ptr=0: req_ready = 001, 010, 100; wb_rdr_o follows the same order.
- Issue x7 three times: cnt=3, and chk_rd=7 with chk_rd_en=1 gives hazard_o=1. One write-back of x7: hazard_o drops. Forcing a 4th iss_en while at 3: err_o=1 and cnt stays at 3.
- Issue x9 in the same cycle that wb_en_o=1 for x9 with cnt[9]=1: cnt[9] stays 1 and busy_o[9]=1.
- Write-back with rdr=0: granted, wb_en_o=0, no counter change, no err_o. Then pulse rst_n low while requests are valid: all state returns to reset values.
